modn_updown_ctr: RTL
====================

// Module: modn_updown_ctr
// PURPOSE
//   Bidirectional modulo-N counter: counts up 0..N-1 or down N-1..0 and wraps.
//   Provides synchronous load and one-cycle carry/borrow pulses so instances can be cascaded.
//   Serves the reverse (count-down) side of the existing up-only modulo counter.
//   Used as the building block for timers and prescalers in the sequential IP set.
// PARAMETERS
//   N      10  modulus; legal range 2 <= N <= 2**WIDTH (elaboration $error otherwise)
//   WIDTH  4   counter/output width in bits
// PORTS
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous reset, active-high
//   en        in   1      count enable; a step occurs only when en=1
//   up_dn     in   1      direction: 1 = increment, 0 = decrement
//   load      in   1      synchronous load strobe
//   load_val  in   WIDTH  value to load
//   out       out  WIDTH  registered count, always in range 0..N-1
//   carry     out  1      registered; 1-cycle pulse on an up-wrap N-1 -> 0
//   borrow    out  1      registered; 1-cycle pulse on a down-wrap 0 -> N-1
// BEHAVIOUR
//   - All state updates occur on the rising edge of clk. There are no combinational input-to-output paths.
//   - Reset (rst=1): out=0, carry=0, borrow=0 at the next edge. rst overrides every other input.
//   - Priority each edge: rst > load > en. up_dn is ignored unless en=1 and load=0.
//   - Load (load=1):
//       out <= (load_val > N-1) ? N-1 : load_val (saturating clamp).
//       carry=0 and borrow=0, even when en=1.
//   - Up step (en=1, up_dn=1):
//       out==N-1 -> out<=0 and carry<=1.
//       Otherwise out<=out+1 and carry<=0.
//   - Down step (en=1, up_dn=0):
//       out==0 -> out<=N-1 and borrow<=1.
//       Otherwise out<=out-1 and borrow<=0.
//   - Idle (en=0, load=0): out holds; carry=0, borrow=0.
//   - carry and borrow are mutually exclusive. Each is high for exactly the cycle
//     in which out shows the post-wrap value. Back-to-back wraps (N=2) give consecutive pulses.
//   - Direction change takes effect on the same edge. There is no pipeline and no penalty cycle.
//   - Latency: every input to out/carry/borrow is exactly 1 clock.
//   - Arithmetic is done in WIDTH bits. The compare against N-1 prevents any binary
//     overflow, including when N == 2**WIDTH.
//   - out never leaves 0..N-1 in any reachable state (assertion in RTL under `ifdef FORMAL).
//   - Reset asserted mid-count or mid-load: the next edge gives out=0 with no pulse, regardless of en/load.
// TESTING
//   1. rst=1 for 2 clk, then en=1, up_dn=1 for 20 clk (N=10).
//      -> out 0..9,0..9; carry high only on the 2 edges where out=0 after 9.
//   2. load=1, load_val=3, then en=1, up_dn=0 for 5 clk.
//      -> out 3,2,1,0,9,8; borrow pulses once with out=9.
//   3. load_val=15 with N=10 -> out=9 (clamped); load=1 together with en=1 -> no carry/borrow.
//   4. At out=9, toggle up_dn every cycle with en=1.
//      -> 9->0 (carry), 0->9 (borrow), 9->0 (carry); pulses alternate.
//   5. Assert rst at out=5 while load=1 and en=1 -> out=0, carry=borrow=0 next edge.
//   6. N=16, WIDTH=4, up 17 clk -> wraps 15->0 with carry. N=2 down -> 1,0,1 with borrow on every 0->1.

Source files
------------

// File: rtl/modn_updown_ctr.sv
// Modulo-N up/down counter with clamped synchronous load and one-cycle carry/borrow pulses for cascading.
// Latency: 1 clk from any input to out/carry/borrow; no backpressure (steps only when en=1, never stalls).
module modn_updown_ctr #(
    parameter int N     = 10,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             borrow
);

    if (N < 2 || N > (1 << WIDTH)) begin : g_bad_n
        $error("modn_updown_ctr: N=%0d outside 2..2**WIDTH (WIDTH=%0d)", N, WIDTH);
    end

    // Comparing against the top value before stepping keeps N == 2**WIDTH from overflowing.
    localparam logic [WIDTH-1:0] TOP = WIDTH'(N - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            out    <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else if (load) begin
            out    <= (load_val > TOP) ? TOP : load_val;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else if (en && up_dn) begin
            borrow <= 1'b0;
            if (out == TOP) begin
                out   <= '0;
                carry <= 1'b1;
            end else begin
                out   <= out + WIDTH'(1);
                carry <= 1'b0;
            end
        end else if (en) begin
            carry <= 1'b0;
            if (out == '0) begin
                out    <= TOP;
                borrow <= 1'b1;
            end else begin
                out    <= out - WIDTH'(1);
                borrow <= 1'b0;
            end
        end else begin
            carry  <= 1'b0;
            borrow <= 1'b0;
        end
    end

`ifdef FORMAL
    always_ff @(posedge clk) begin
        assert (out <= TOP);
        assert (!(carry && borrow));
    end
`endif

endmodule
